b1_linebuf: RTL and testbench

B1_LINEBUF -- requirements
Module: b1_linebuf

---
 rtl/b1_linebuf_pkg.sv | 11 +
 rtl/b1_linebuf_ram.sv | 21 ++
 rtl/b1_linebuf.sv | 98 +++++++++
 tb/tb_b1_linebuf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/b1_linebuf_pkg.sv
// Shared constants for the sprite line buffer: geometry, entry width, transparent colour.
package b1_linebuf_pkg;
  localparam int         LB_DEPTH       = 512;
  localparam int         LB_WIDTH       = 12;
  localparam int         LB_AW          = 9;
  localparam logic [3:0] LB_TRANSPARENT = 4'h0;

  function automatic logic [LB_AW-1:0] lb_next_addr(input logic [LB_AW-1:0] addr, input int depth);
    return (int'(addr) == depth - 1) ? '0 : addr + LB_AW'(1);
  endfunction
endpackage

// File: rtl/b1_linebuf_ram.sv
// One line buffer: synchronous single write port, asynchronous read port, no reset on contents.
module linebuf_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 12,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdat
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
  end

  assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/b1_linebuf.sv
// Ping-pong sprite line buffer: one buffer collects sprite pixels while the other is
// read out (latency 1 per PIX_CE) and cleared behind the read pointer.
module b1_linebuf
  import b1_linebuf_pkg::*;
#(
  parameter int LB_DEPTH = b1_linebuf_pkg::LB_DEPTH
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        PIX_CE,
  input  logic [23:0] PBUS,
  input  logic        PCK1,
  input  logic        LOAD,
  input  logic        SPR_WE,
  input  logic [3:0]  SPR_COLOR,
  input  logic        WR_PIXEL,
  input  logic        EVEN,
  input  logic        LINE_START,
  output logic [11:0] PIX_OUT,
  output logic        PIX_VALID
);
  logic                r_even;
  logic [7:0]          r_pal_latch;
  logic [LB_AW-1:0]    r_x_latch;
  logic [LB_AW-1:0]    r_waddr;
  logic [LB_AW-1:0]    r_raddr;
  logic [LB_WIDTH-1:0] r_pix_out;
  logic                r_pix_valid;

  logic [LB_AW-1:0]    w_wbase;
  logic                w_keep;
  logic                w_spr_we;
  logic                w_rd_en;
  logic [LB_WIDTH-1:0] w_spr_dat;
  logic [LB_WIDTH-1:0] w_rdat_a;
  logic [LB_WIDTH-1:0] w_rdat_b;
  logic [LB_WIDTH-1:0] w_rd_dat;

  // LOAD redirects the current pixel to the strip origin in the same cycle.
  assign w_wbase   = LOAD ? r_x_latch : r_waddr;
  assign w_keep    = SPR_WE & WR_PIXEL;
  assign w_spr_we  = w_keep & (SPR_COLOR != LB_TRANSPARENT);
  assign w_rd_en   = PIX_CE & ~LINE_START;
  assign w_spr_dat = {r_pal_latch, SPR_COLOR};
  assign w_rd_dat  = r_even ? w_rdat_a : w_rdat_b;

  // r_even=1: A is read/cleared, B collects sprites; roles swap when r_even=0.
  linebuf_ram #(.DEPTH(LB_DEPTH), .WIDTH(LB_WIDTH), .AW(LB_AW)) u_buf_a (
    .clk     (CLK_24M),
    .i_we    (r_even ? w_rd_en : w_spr_we),
    .i_waddr (r_even ? r_raddr : w_wbase),
    .i_wdat  (r_even ? '0 : w_spr_dat),
    .i_raddr (r_raddr),
    .o_rdat  (w_rdat_a)
  );

  linebuf_ram #(.DEPTH(LB_DEPTH), .WIDTH(LB_WIDTH), .AW(LB_AW)) u_buf_b (
    .clk     (CLK_24M),
    .i_we    (r_even ? w_spr_we : w_rd_en),
    .i_waddr (r_even ? w_wbase : r_raddr),
    .i_wdat  (r_even ? w_spr_dat : '0),
    .i_raddr (r_raddr),
    .o_rdat  (w_rdat_b)
  );

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_even      <= 1'b0;
      r_pal_latch <= '0;
      r_x_latch   <= '0;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_pix_out   <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_even <= EVEN;
      if (PCK1) begin
        r_pal_latch <= PBUS[23:16];
        r_x_latch   <= PBUS[8:0];
      end
      if (w_keep) begin
        r_waddr <= lb_next_addr(w_wbase, LB_DEPTH);
      end else if (LOAD) begin
        r_waddr <= r_x_latch;
      end
      r_pix_valid <= w_rd_en;
      if (LINE_START) begin
        r_raddr <= '0;
      end else if (PIX_CE) begin
        r_pix_out <= w_rd_dat;
        r_raddr   <= lb_next_addr(r_raddr, LB_DEPTH);
      end
    end
  end

  assign PIX_OUT   = r_pix_out;
  assign PIX_VALID = r_pix_valid;
endmodule

// File: tb/tb_b1_linebuf.sv
// Directed bench for b1_linebuf: strip writes, shrink/transparency, wrap, overlap, read-clear, reset.
module tb_b1_linebuf;
  logic        CLK_24M = 1'b0;
  logic        nRESET = 1'b0;
  logic        PIX_CE = 1'b0;
  logic [23:0] PBUS = '0;
  logic        PCK1 = 1'b0;
  logic        LOAD = 1'b0;
  logic        SPR_WE = 1'b0;
  logic [3:0]  SPR_COLOR = '0;
  logic        WR_PIXEL = 1'b0;
  logic        EVEN = 1'b0;
  logic        LINE_START = 1'b0;
  logic [11:0] PIX_OUT;
  logic        PIX_VALID;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_mem [512];

  b1_linebuf #(.LB_DEPTH(512)) dut (
    .CLK_24M    (CLK_24M),
    .nRESET     (nRESET),
    .PIX_CE     (PIX_CE),
    .PBUS       (PBUS),
    .PCK1       (PCK1),
    .LOAD       (LOAD),
    .SPR_WE     (SPR_WE),
    .SPR_COLOR  (SPR_COLOR),
    .WR_PIXEL   (WR_PIXEL),
    .EVEN       (EVEN),
    .LINE_START (LINE_START),
    .PIX_OUT    (PIX_OUT),
    .PIX_VALID  (PIX_VALID)
  );

  always #20 CLK_24M = ~CLK_24M;

  task automatic tick();
    @(posedge CLK_24M);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_even(input logic e);
    EVEN = e;
    tick();
  endtask

  task automatic latch(input logic [23:0] p);
    PBUS = p;
    PCK1 = 1'b1;
    tick();
    PCK1 = 1'b0;
    PBUS = '0;
  endtask

  task automatic write_pix(input logic [3:0] c, input logic keep, input logic ld);
    SPR_WE = 1'b1;
    SPR_COLOR = c;
    WR_PIXEL = keep;
    LOAD = ld;
    tick();
    SPR_WE = 1'b0;
    SPR_COLOR = '0;
    WR_PIXEL = 1'b0;
    LOAD = 1'b0;
  endtask

  task automatic start_line(input logic with_ce);
    LINE_START = 1'b1;
    PIX_CE = with_ce;
    tick();
    LINE_START = 1'b0;
    PIX_CE = 1'b0;
    check("line_start_valid", {11'd0, PIX_VALID}, 12'd0);
  endtask

  // One PIX_CE followed by three idle cycles (6 MHz cadence).
  task automatic read_one(input string tag, input logic [11:0] exp, input logic chk);
    PIX_CE = 1'b1;
    tick();
    PIX_CE = 1'b0;
    if (chk) begin
      check({tag, "_valid"}, {11'd0, PIX_VALID}, 12'd1);
      check(tag, PIX_OUT, exp);
    end
    tick();
    if (chk) begin
      check({tag, "_pulse"}, {11'd0, PIX_VALID}, 12'd0);
      check({tag, "_hold"}, PIX_OUT, exp);
    end
    tick();
    tick();
  endtask

  task automatic clear_exp();
    foreach (exp_mem[i]) exp_mem[i] = 12'h000;
  endtask

  task automatic read_pass(input string tag, input logic with_ce, input logic chk);
    start_line(with_ce);
    for (int i = 0; i < 512; i++) begin
      read_one($sformatf("%s[%0d]", tag, i), exp_mem[i], chk);
    end
  endtask

  initial begin
    logic [11:0] seq35 [10];
    seq35 = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
              12'h2A1, 12'h2A2, 12'h2A3, 12'h2A4, 12'h000};

    #5;
    check("reset_pix_out", PIX_OUT, 12'h000);
    check("reset_pix_valid", {11'd0, PIX_VALID}, 12'd0);
    tick();
    nRESET = 1'b1;
    tick();

    // Scrub both buffers so later expectations start from zero.
    clear_exp();
    set_even(1'b0);
    read_pass("scrub_b", 1'b0, 1'b0);
    set_even(1'b1);
    read_pass("scrub_a", 1'b0, 1'b0);

    // Strip at X=5, palette 2A into buffer A, then read it out and re-read.
    set_even(1'b0);
    latch(24'h2A_0005);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int c = 1; c <= 4; c++) write_pix(4'(c), 1'b1, 1'b0);
    set_even(1'b1);
    start_line(1'b0);
    for (int i = 0; i < 10; i++) read_one($sformatf("strip5[%0d]", i), seq35[i], 1'b1);
    start_line(1'b0);
    for (int i = 0; i < 10; i++) read_one($sformatf("reread[%0d]", i), 12'h000, 1'b1);

    // Wrap at 511 with LOAD coincident with the first pixel; line start collides with PIX_CE.
    set_even(1'b0);
    latch(24'h01_01FE);
    write_pix(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) write_pix(4'hF, 1'b1, 1'b0);
    set_even(1'b1);
    clear_exp();
    exp_mem[0] = 12'h01F;
    exp_mem[1] = 12'h01F;
    exp_mem[510] = 12'h01F;
    exp_mem[511] = 12'h01F;
    read_pass("wrap", 1'b1, 1'b1);

    // Shrink and transparency at X=0x20.
    set_even(1'b0);
    latch(24'h55_0020);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    write_pix(4'h7, 1'b1, 1'b0);
    write_pix(4'h7, 1'b0, 1'b0);
    write_pix(4'h7, 1'b1, 1'b0);
    write_pix(4'h0, 1'b1, 1'b0);
    write_pix(4'h7, 1'b1, 1'b0);
    set_even(1'b1);
    clear_exp();
    exp_mem[9'h20] = 12'h557;
    exp_mem[9'h21] = 12'h557;
    exp_mem[9'h23] = 12'h557;
    read_pass("shrink", 1'b0, 1'b1);

    // Overlapping strips into buffer B; the later one wins at X=10.
    set_even(1'b1);
    latch(24'h11_0008);
    write_pix(4'h1, 1'b1, 1'b1);
    write_pix(4'h2, 1'b1, 1'b0);
    write_pix(4'h3, 1'b1, 1'b0);
    latch(24'h33_000A);
    write_pix(4'hC, 1'b1, 1'b1);
    write_pix(4'hD, 1'b1, 1'b0);
    set_even(1'b0);
    clear_exp();
    exp_mem[8] = 12'h111;
    exp_mem[9] = 12'h112;
    exp_mem[10] = 12'h33C;
    exp_mem[11] = 12'h33D;
    read_pass("overlap", 1'b0, 1'b1);

    // Reset in the middle of a read pass.
    latch(24'h77_0000);
    write_pix(4'h5, 1'b1, 1'b1);
    write_pix(4'h6, 1'b1, 1'b0);
    latch(24'h44_0100);
    set_even(1'b1);
    start_line(1'b0);
    PIX_CE = 1'b1;
    tick();
    PIX_CE = 1'b0;
    check("pre_rst_out", PIX_OUT, 12'h775);
    check("pre_rst_valid", {11'd0, PIX_VALID}, 12'd1);
    #5 nRESET = 1'b0;
    #1;
    check("rst_pix_out", PIX_OUT, 12'h000);
    check("rst_pix_valid", {11'd0, PIX_VALID}, 12'd0);
    tick();
    nRESET = 1'b1;
    tick();
    read_one("post_rst0", 12'h000, 1'b1);
    read_one("post_rst1", 12'h776, 1'b1);

    // Address and latches were cleared by reset: no LOAD/PCK1 writes at 0 with palette 0.
    set_even(1'b0);
    write_pix(4'h9, 1'b1, 1'b0);
    write_pix(4'h6, 1'b1, 1'b0);
    write_pix(4'h3, 1'b1, 1'b1);
    set_even(1'b1);
    clear_exp();
    exp_mem[0] = 12'h003;
    exp_mem[1] = 12'h006;
    read_pass("post_rst_wr", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
